// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch vs. data) sharing one memory port,
// with a bounded data-priority streak so fetches cannot starve.
module mem_arbiter #(
  parameter int unsigned FAIR_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        if_stall,
  output logic        mem_stall,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a master holds req and its fields until its ready pulse; the
  // bus request is held until bus_ready, which completes it in that same cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  localparam logic [3:0] FAIR_LIM = 4'(FAIR_MAX);

  state_e      state_q;
  logic [3:0]  streak_q;
  logic        bus_valid_q;
  logic        bus_we_q;
  logic [3:0]  bus_wstrb_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic        if_ready_q;
  logic        d_ready_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic        data_win;
  logic [3:0]  streak_d;

  // Data wins unless a fetch is waiting and data has already had its streak.
  assign data_win = d_req && (!if_req || (streak_q < FAIR_LIM));
  assign streak_d = (streak_q >= FAIR_LIM) ? FAIR_LIM : streak_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= 4'd0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (data_win) begin
            state_q     <= DATA;
            bus_valid_q <= 1'b1;
            bus_we_q    <= d_we;
            bus_wstrb_q <= d_wstrb;
            bus_addr_q  <= d_addr;
            bus_wdata_q <= d_wdata;
            streak_q    <= if_req ? streak_d : 4'd0;
          end else if (if_req) begin
            state_q     <= FETCH;
            bus_valid_q <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_wstrb_q <= 4'd0;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= 32'd0;
            streak_q    <= 4'd0;
          end
        end
        FETCH: begin
          if (bus_ready) begin
            if_rdata_q  <= bus_rdata;
            if_ready_q  <= 1'b1;
            bus_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        DATA: begin
          if (bus_ready) begin
            d_rdata_q   <= bus_rdata;
            d_ready_q   <= 1'b1;
            bus_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_valid   = bus_valid_q;
  assign bus_we      = bus_we_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign if_ready    = if_ready_q;
  assign if_rdata    = if_rdata_q;
  assign d_ready     = d_ready_q;
  assign d_rdata     = d_rdata_q;
  assign if_stall    = if_req && !if_ready_q;
  assign mem_stall   = d_req && !d_ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two queue-driven masters, a wait-state slave model,
// a bus monitor logging grants, and rdata scoreboards per requester.
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dcmd_t;

  typedef struct {
    int          cyc;
    logic        is_data;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rdy_edge = 1'b0;

  logic [31:0] if_cmd_q[$];
  dcmd_t       d_cmd_q[$];
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  grant_t      grant_q[$];

  int   if_req_cyc, if_done_cyc, d_req_cyc, d_done_cyc;
  int   d_done_n = 0;
  logic d_drop = 1'b0;
  logic slave_en = 1'b1;
  logic force_ready = 1'b0;
  logic rand_wait = 1'b0;
  int   wait_states = 0;

  mem_arbiter #(.FAIR_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall), .dbg_state_o(dbg_state)
  );

  // Clock / reset-time bookkeeping
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_edge <= bus_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave memory contents as a pure function of address.
  function automatic logic [31:0] rd_func(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_d(input logic we, input logic [3:0] strb, input logic [31:0] a,
                        input logic [31:0] wd);
    dcmd_t c;
    c.we = we; c.wstrb = strb; c.addr = a; c.wdata = wd;
    d_cmd_q.push_back(c);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while (n < 3000 && !(if_cmd_q.size() == 0 && d_cmd_q.size() == 0 &&
           if_exp_q.size() == 0 && d_exp_q.size() == 0 && !if_req && !d_req &&
           dbg_state == 2'd0)) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    tick();
  endtask

  // Fetch master driver
  initial begin
    if_req = 1'b0;
    if_addr = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (if_ready) begin
        if_done_cyc = cyc;
        check("if_spurious_ready", 64'(if_exp_q.size() != 0), 64'd1);
        if (if_exp_q.size() != 0) check("if_rdata", 64'(if_rdata), 64'(if_exp_q.pop_front()));
        if_req = 1'b0;
      end
      if (!if_req && !rst && if_exp_q.size() == 0 && if_cmd_q.size() != 0) begin
        if_addr = if_cmd_q.pop_front();
        if_exp_q.push_back(rd_func(if_addr));
        if_req = 1'b1;
        if_req_cyc = cyc;
      end
    end
  end

  // Data master driver
  initial begin
    dcmd_t c;
    d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (d_ready) begin
        d_done_cyc = cyc;
        d_done_n++;
        check("d_spurious_ready", 64'(d_exp_q.size() != 0), 64'd1);
        if (d_exp_q.size() != 0) check("d_rdata", 64'(d_rdata), 64'(d_exp_q.pop_front()));
        d_req = 1'b0;
      end
      if (d_drop) begin
        d_req = 1'b0;
      end else if (!d_req && !rst && d_exp_q.size() == 0 && d_cmd_q.size() != 0) begin
        c = d_cmd_q.pop_front();
        d_we = c.we; d_wstrb = c.wstrb; d_addr = c.addr; d_wdata = c.wdata;
        d_exp_q.push_back(rd_func(c.addr));
        d_req = 1'b1;
        d_req_cyc = cyc;
      end
    end
  end

  // Slave model: completes after cur_wait extra cycles of bus_valid
  initial begin
    int cnt = 0;
    int cur_wait = 0;
    bus_ready = 1'b0;
    bus_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk); #1;
      if (!slave_en) begin
        bus_ready = force_ready;
        bus_rdata = 32'hBAD0_BAD0;
        cnt = 0;
      end else if (bus_valid && !bus_ready) begin
        if (cnt == 0) cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_states;
        if (cnt == cur_wait) begin
          bus_ready = 1'b1;
          bus_rdata = rd_func(bus_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        bus_ready = 1'b0;
        bus_rdata = 32'hBAD0_BAD0;
        if (!bus_valid) cnt = 0;
      end
    end
  end

  // Bus monitor: grant log, field hold, idle gap after completion
  initial begin
    grant_t g;
    logic prev_valid = 1'b0;
    logic [36:0] h_ctl;
    logic [31:0] h_wdata;
    forever begin
      @(posedge clk); #1;
      if (prev_valid && bus_valid && !rdy_edge) begin
        check("bus_hold_ctl", 64'({bus_we, bus_wstrb, bus_addr}), 64'(h_ctl));
        check("bus_hold_wdata", 64'(bus_wdata), 64'(h_wdata));
      end
      if (prev_valid && rdy_edge) check("bus_gap", 64'(bus_valid), 64'd0);
      if (bus_valid && !prev_valid) begin
        g.cyc = cyc; g.is_data = (bus_addr >= 32'h2000); g.we = bus_we;
        g.wstrb = bus_wstrb; g.addr = bus_addr; g.wdata = bus_wdata;
        grant_q.push_back(g);
        if (!g.is_data) check("fetch_zero_fields", 64'({bus_we, bus_wstrb, bus_wdata}), 64'd0);
      end
      prev_valid = bus_valid;
      h_ctl = {bus_we, bus_wstrb, bus_addr};
      h_wdata = bus_wdata;
    end
  end

  // Directed and random sequences
  initial begin
    int g0, n;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_bus_fields", 64'({bus_we, bus_wstrb, bus_addr}), 64'd0);
    check("rst_bus_wdata", 64'(bus_wdata), 64'd0);
    check("rst_readies", 64'({if_ready, d_ready}), 64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_stalls", 64'({if_stall, mem_stall}), 64'd0);
    rst = 1'b0;
    tick();

    // Lone fetch, zero-wait slave
    wait_states = 0;
    g0 = grant_q.size();
    if_cmd_q.push_back(32'h100);
    wait_quiet("fetch_only");
    check("fetch_grant_lat", 64'(grant_q[g0].cyc - if_req_cyc), 64'd1);
    check("fetch_grant_addr", 64'(grant_q[g0].addr), 64'h100);
    check("fetch_ready_lat", 64'(if_done_cyc - if_req_cyc), 64'd2);
    check("fetch_rdata", 64'(if_rdata), 64'h13);

    // Store with three wait states
    wait_states = 3;
    g0 = grant_q.size();
    push_d(1'b1, 4'b0011, 32'h2000, 32'hBEEF);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("store_mem_stall", 64'(mem_stall), 64'd1);
      tick();
    end
    check("store_d_ready", 64'(d_ready), 64'd1);
    check("store_stall_clear", 64'(mem_stall), 64'd0);
    check("store_ready_lat", 64'(d_done_cyc - d_req_cyc), 64'd5);
    check("store_grant_lat", 64'(grant_q[g0].cyc - d_req_cyc), 64'd1);
    check("store_fields", 64'({grant_q[g0].we, grant_q[g0].wstrb, grant_q[g0].addr}),
          64'({1'b1, 4'b0011, 32'h2000}));
    check("store_wdata", 64'(grant_q[g0].wdata), 64'hBEEF);
    wait_quiet("store");

    // Simultaneous fetch and load: data first
    wait_states = 1;
    g0 = grant_q.size();
    if_cmd_q.push_back(32'h1004);
    push_d(1'b0, 4'b0000, 32'h2010, 32'h0);
    tick();
    n = 0;
    while (!if_ready && n < 40) begin
      check("simul_if_stall", 64'(if_stall), 64'd1);
      tick();
      n++;
    end
    check("simul_timeout", 64'(n < 40), 64'd1);
    wait_quiet("simul");
    check("simul_grants", 64'(grant_q.size() - g0), 64'd2);
    check("simul_first_data", 64'(grant_q[g0].is_data), 64'd1);
    check("simul_second_fetch", 64'(grant_q[g0 + 1].is_data), 64'd0);
    check("simul_fetch_after_dready", 64'(grant_q[g0 + 1].cyc - d_done_cyc), 64'd1);

    // bus_ready while idle must be ignored
    slave_en = 1'b0;
    force_ready = 1'b1;
    repeat (3) begin
      tick();
      check("idle_ready_readies", 64'({if_ready, d_ready}), 64'd0);
      check("idle_ready_state", 64'({bus_valid, dbg_state}), 64'd0);
    end
    force_ready = 1'b0;
    tick();
    check("idle_ready_if_rdata", 64'(if_rdata), 64'(rd_func(32'h1004)));
    check("idle_ready_d_rdata", 64'(d_rdata), 64'(rd_func(32'h2010)));
    slave_en = 1'b1;
    tick();

    // Owner drops its request mid-transaction
    wait_states = 4;
    g0 = grant_q.size();
    n = d_done_n;
    push_d(1'b0, 4'b0000, 32'h2040, 32'h0);
    for (int i = 0; i < 20 && grant_q.size() == g0; i++) tick();
    d_drop = 1'b1;
    for (int i = 0; i < 20 && d_done_n == n; i++) tick();
    check("drop_completes", 64'(d_done_n - n), 64'd1);
    check("drop_rdata", 64'(d_rdata), 64'(rd_func(32'h2040)));
    d_drop = 1'b0;
    wait_quiet("drop");

    // Fairness: 4 data grants then 1 fetch while both stay requested
    wait_states = 0;
    g0 = grant_q.size();
    for (int i = 0; i < 10; i++) if_cmd_q.push_back(32'h1000 + 32'(4 * i));
    for (int i = 0; i < 40; i++) push_d(1'b0, 4'b0000, 32'h2100 + 32'(4 * i), 32'h0);
    wait_quiet("fair");
    check("fair_grant_count", 64'(grant_q.size() - g0), 64'd50);
    for (int i = 0; i < 50; i++)
      check($sformatf("fair_grant_%0d", i), 64'(grant_q[g0 + i].is_data), 64'((i % 5) != 4));

    // Reset during a data access
    wait_states = 10;
    n = d_done_n;
    push_d(1'b1, 4'hF, 32'h2080, 32'h1234_5678);
    for (int i = 0; i < 20 && !(bus_valid && dbg_state == 2'd2); i++) tick();
    check("rstmid_in_data", 64'({bus_valid, dbg_state}), 64'({1'b1, 2'd2}));
    d_drop = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_exp_q.delete();
    check("rstmid_bus_valid", 64'(bus_valid), 64'd0);
    check("rstmid_state", 64'(dbg_state), 64'd0);
    check("rstmid_d_rdata", 64'(d_rdata), 64'd0);
    slave_en = 1'b0;
    force_ready = 1'b1;
    repeat (3) begin
      tick();
      check("rstmid_no_ready", 64'({if_ready, d_ready, bus_valid}), 64'd0);
    end
    force_ready = 1'b0;
    tick();
    check("rstmid_no_dready", 64'(d_done_n - n), 64'd0);
    check("rstmid_d_rdata_hold", 64'(d_rdata), 64'd0);
    slave_en = 1'b1;
    d_drop = 1'b0;
    tick();

    // Random mix with random wait states
    rand_wait = 1'b1;
    for (int i = 0; i < 15; i++) if_cmd_q.push_back(32'h1000 + 32'(4 * $urandom_range(0, 255)));
    for (int i = 0; i < 20; i++)
      push_d(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             32'h2000 + 32'(4 * $urandom_range(0, 255)), $urandom);
    wait_quiet("random");

    check("end_if_exp_empty", 64'(if_exp_q.size()), 64'd0);
    check("end_d_exp_empty", 64'(d_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
